ps_pl_mailbox_slave: RTL

- AXI4-Lite responder (slave) that terminates the PS-side master's single-beat write and read transfers into a 4-register command/response mailbox.
- Write side: PS writes an argument and a command, which raises a doorbell handshake toward PL logic.
- Read side: PL returns a 32-bit result, which PS reads back; status flags are visible to PS.
- Sits between the PS AXI interconnect (GP port) and user PL logic.

---
 rtl/ps_pl_mailbox_slave_if.sv | 41 ++++
 rtl/ps_pl_mailbox_slave.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps_pl_mailbox_slave_if.sv
// AXI4-Lite bus bundle between the PS GP master and the mailbox responder.
interface ps_pl_mailbox_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,    output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,                 input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,    input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,    input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,                 output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,    output S_AXI_RREADY
    );
endinterface

// File: rtl/ps_pl_mailbox_slave.sv
// AXI4-Lite command/response mailbox: CMD, ARG, RESP, STATUS with PL doorbell handshakes.
// Define MAILBOX_IRQ_EN to add the irq output and the STATUS[31] IRQ_ENABLE bit.
module ps_pl_mailbox_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] ARG_RESET          = 32'h0
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    ps_pl_mailbox_slave_if.slave s_axi,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [31:0]          cmd_data,
    output logic [31:0]          cmd_arg,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic [31:0]          rsp_data
`ifdef MAILBOX_IRQ_EN
   ,output logic                 irq
`endif
);
    localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    logic [0:0]  r_wstate, r_rstate;
    logic        r_aw_got, r_w_got, r_awready, r_wready, r_bvalid;
    logic [1:0]  r_awaddr, r_bresp;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_arready, r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_cmd, r_arg, r_resp;
    logic        r_cmd_valid, r_resp_full, r_rsp_ready;

    logic        w_aw_hs, w_w_hs, w_wr_go, w_wr_err, w_wr_cmd, w_wr_arg, w_wr_sts;
    logic        w_cmd_hs, w_rsp_hs, w_resp_clr, w_resp_full_nxt, w_irq_en;
    logic [1:0]  w_waddr;
    logic [31:0] w_wdata, w_rd_mux;
    logic [3:0]  w_wstrb;

    function automatic logic [31:0] f_mask(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            f_mask[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    endfunction

    // A channel handshaking this cycle counts as latched, so the update lands on that edge.
    assign w_aw_hs  = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs   = s_axi.S_AXI_WVALID & r_wready;
    assign w_wr_go  = (r_wstate == W_IDLE) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
    assign w_waddr  = r_aw_got ? r_awaddr : s_axi.S_AXI_AWADDR[3:2];
    assign w_wdata  = r_w_got  ? r_wdata  : s_axi.S_AXI_WDATA;
    assign w_wstrb  = r_w_got  ? r_wstrb  : s_axi.S_AXI_WSTRB;

    assign w_wr_err = (w_waddr == 2'd2) | ((w_waddr == 2'd0) & r_cmd_valid);
    assign w_wr_cmd = w_wr_go & (w_waddr == 2'd0) & ~r_cmd_valid;
    assign w_wr_arg = w_wr_go & (w_waddr == 2'd1);
    assign w_wr_sts = w_wr_go & (w_waddr == 2'd3);

    assign w_cmd_hs        = r_cmd_valid & cmd_ready;
    assign w_rsp_hs        = rsp_valid & r_rsp_ready;
    assign w_resp_clr      = w_wr_sts & w_wstrb[0] & w_wdata[1];
    assign w_resp_full_nxt = w_rsp_hs | (r_resp_full & ~w_resp_clr);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awaddr  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (r_wstate == W_IDLE) begin
            if (w_wr_go) begin
                r_wstate  <= W_RESP;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
                r_aw_got  <= 1'b0;
                r_w_got   <= 1'b0;
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_got <= 1'b1;
                    r_awaddr <= s_axi.S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    r_w_got <= 1'b1;
                    r_wdata <= s_axi.S_AXI_WDATA;
                    r_wstrb <= s_axi.S_AXI_WSTRB;
                end
                r_awready <= ~(r_aw_got | w_aw_hs);
                r_wready  <= ~(r_w_got | w_w_hs);
            end
        end else if (s_axi.S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cmd       <= 32'd0;
            r_arg       <= ARG_RESET;
            r_resp      <= 32'd0;
            r_cmd_valid <= 1'b0;
            r_resp_full <= 1'b0;
            r_rsp_ready <= 1'b0;
        end else begin
            // CMD writes only land while idle, so they never collide with the PL handshake.
            if (w_wr_cmd) begin
                r_cmd       <= f_mask(r_cmd, w_wdata, w_wstrb);
                r_cmd_valid <= 1'b1;
            end else if (w_cmd_hs) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_wr_arg) r_arg  <= f_mask(r_arg, w_wdata, w_wstrb);
            if (w_rsp_hs) r_resp <= rsp_data;
            r_resp_full <= w_resp_full_nxt;
            r_rsp_ready <= ~w_resp_full_nxt;
        end
    end

`ifdef MAILBOX_IRQ_EN
    logic r_irq_en, r_irq;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_sts & w_wstrb[3]) r_irq_en <= w_wdata[31];
            r_irq <= r_resp_full & r_irq_en;
        end
    end
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    always_comb begin
        w_rd_mux = 32'd0;
        case (s_axi.S_AXI_ARADDR[3:2])
            2'd0:    w_rd_mux = r_cmd;
            2'd1:    w_rd_mux = r_arg;
            2'd2:    w_rd_mux = r_resp;
            default: w_rd_mux = {w_irq_en, 29'd0, r_resp_full, r_cmd_valid};
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else if (r_rstate == R_IDLE) begin
            if (s_axi.S_AXI_ARVALID & r_arready) begin
                r_rstate  <= R_DATA;
                r_rdata   <= w_rd_mux;
                r_rvalid  <= 1'b1;
                r_arready <= 1'b0;
            end else begin
                r_arready <= 1'b1;
            end
        end else if (s_axi.S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign cmd_valid = r_cmd_valid;
    assign cmd_data  = r_cmd;
    assign cmd_arg   = r_arg;
    assign rsp_ready = r_rsp_ready;

    logic w_unused;
    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule
